// File: rtl/ir_pkg.sv
// ir_pkg -- shared definitions for the NEC IR frame controller.
//   ir_state_t     : FSM state encoding (also driven out on state_O)
//   ERR_*          : err_code_O values
//   TICK_DIV       : CLOCK_50 cycles per 50 us tick
//   *_MIN / *_MAX  : duration windows in ticks (inclusive)
package ir_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LEAD_LOW  = 3'd1,
      ST_LEAD_HIGH = 3'd2,
      ST_DATA      = 3'd3,
      ST_CHECK     = 3'd4
   } ir_state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_PROTO = 2'b01;
   localparam logic [1:0] ERR_CSUM  = 2'b10;
   localparam logic [1:0] ERR_OVRN  = 2'b11;

   localparam int TICK_DIV = 2500;

   // 9 ms leader low
   localparam logic [7:0] LEAD_LOW_MIN  = 8'd160;
   localparam logic [7:0] LEAD_LOW_MAX  = 8'd200;
   // 4.5 ms leader high (data frame follows)
   localparam logic [7:0] LEAD_HIGH_MIN = 8'd80;
   localparam logic [7:0] LEAD_HIGH_MAX = 8'd100;
   // 2.25 ms leader high (repeat code)
   localparam logic [7:0] REP_HIGH_MIN  = 8'd36;
   localparam logic [7:0] REP_HIGH_MAX  = 8'd54;
   // 12 ms of silence inside a frame
   localparam logic [7:0] DATA_TIMEOUT  = 8'd240;

   function automatic logic in_window(input logic [7:0] v,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   // Only the command byte pair is protected; address bytes may be extended NEC.
   function automatic logic csum_ok(input logic [31:0] f);
      return f[23:16] == ~f[31:24];
   endfunction

endpackage

// File: rtl/ir_tick_timer.sv
// ir_tick_timer -- 50 us tick prescaler and saturating duration counter.
//   CLOCK_50 : system clock
//   rst_n    : async active-low reset
//   clr_I    : restart both prescaler and duration (any IR edge)
//   dur_O    : ticks elapsed since last clear, saturating at 255
module ir_tick_timer #(
   parameter int TICK_DIV = ir_pkg::TICK_DIV
) (
   input  logic       CLOCK_50,
   input  logic       rst_n,
   input  logic       clr_I,
   output logic [7:0] dur_O
);

   localparam logic [11:0] PRESC_LAST = 12'(TICK_DIV - 1);

   logic [11:0] r_presc;
   logic [7:0]  r_dur;
   logic        w_tick;

   assign w_tick = (r_presc == PRESC_LAST);
   assign dur_O  = r_dur;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_dur   <= '0;
      end else if (clr_I) begin
         r_presc <= '0;
         r_dur   <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
         if (r_dur != 8'hFF) begin
            r_dur <= r_dur + 8'd1;
         end
      end else begin
         r_presc <= r_presc + 12'd1;
      end
   end

endmodule

// File: rtl/ir_frame_ctrl.sv
// ir_frame_ctrl -- NEC IR frame decoder: leader qualification, 32-bit
// LSB-first shifter, command checksum and a valid/ready output register.
//   CLOCK_50, rst_n         : clock, async active-low reset
//   ir_neg_I / ir_pos_I     : IRDA_RXD falling / rising edge pulses
//   bit0_I / bit1_I         : classified bit pulses
//   frame_rdy_I             : consumer ready
//   frame_data_O/frame_vld_O: {cmd_n, cmd, addr_n, addr}, held while valid
//   repeat_O, err_O         : single-cycle event pulses
//   err_code_O              : cause of the most recent error
//   state_O                 : FSM state for debug
//
// state      | meaning
// IDLE       | waiting for burst start
// LEAD_LOW   | timing the 9 ms leader low
// LEAD_HIGH  | timing the leader high (4.5 ms frame / 2.25 ms repeat)
// DATA       | shifting in 32 bits, watching for 12 ms silence
// CHECK      | one cycle: checksum, then load or drop the frame
module ir_frame_ctrl
   import ir_pkg::*;
#(
   parameter int P_TICK_DIV = TICK_DIV
) (
   input  logic        CLOCK_50,
   input  logic        rst_n,
   input  logic        ir_neg_I,
   input  logic        ir_pos_I,
   input  logic        bit0_I,
   input  logic        bit1_I,
   input  logic        frame_rdy_I,
   output logic [31:0] frame_data_O,
   output logic        frame_vld_O,
   output logic        repeat_O,
   output logic        err_O,
   output logic [1:0]  err_code_O,
   output logic [2:0]  state_O
);

   ir_state_t   r_state;
   ir_state_t   w_state_nxt;
   logic [31:0] r_shift;
   logic [5:0]  r_bit_cnt;
   logic        r_last_ok;
   logic [31:0] r_frame_data;
   logic        r_frame_vld;
   logic        r_repeat;
   logic        r_err;
   logic [1:0]  r_err_code;

   logic [7:0]  w_dur;
   logic        w_xfer;
   logic        w_err_set;
   logic [1:0]  w_err_code_nxt;
   logic        w_rep_set;
   logic        w_shift_en;
   logic        w_cnt_clr;
   logic        w_load;
   logic        w_ok_set;
   logic        w_ok_clr;

   ir_tick_timer #(.TICK_DIV(P_TICK_DIV)) u_timer (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .clr_I    (ir_neg_I | ir_pos_I),
      .dur_O    (w_dur)
   );

   assign w_xfer = r_frame_vld & frame_rdy_I;

   always_comb begin
      w_state_nxt    = r_state;
      w_err_set      = 1'b0;
      w_err_code_nxt = r_err_code;
      w_rep_set      = 1'b0;
      w_shift_en     = 1'b0;
      w_cnt_clr      = 1'b0;
      w_load         = 1'b0;
      w_ok_set       = 1'b0;
      w_ok_clr       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (ir_neg_I) begin
               w_state_nxt = ST_LEAD_LOW;
            end
         end

         ST_LEAD_LOW: begin
            if (ir_pos_I) begin
               if (in_window(w_dur, LEAD_LOW_MIN, LEAD_LOW_MAX)) begin
                  w_state_nxt = ST_LEAD_HIGH;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end

         ST_LEAD_HIGH: begin
            if (ir_neg_I) begin
               if (in_window(w_dur, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) begin
                  w_state_nxt = ST_DATA;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
                  // a repeat only means something if the previous frame was good
                  if (in_window(w_dur, REP_HIGH_MIN, REP_HIGH_MAX)) begin
                     w_rep_set = r_last_ok;
                  end
               end
            end
         end

         ST_DATA: begin
            if (bit0_I && bit1_I) begin
               w_state_nxt    = ST_IDLE;
               w_err_set      = 1'b1;
               w_err_code_nxt = ERR_PROTO;
            end else if (bit0_I || bit1_I) begin
               w_shift_en = 1'b1;
               if (r_bit_cnt == 6'd31) begin
                  w_state_nxt = ST_CHECK;
               end
            end else if (w_dur >= DATA_TIMEOUT) begin
               w_state_nxt    = ST_IDLE;
               w_err_set      = 1'b1;
               w_err_code_nxt = ERR_PROTO;
            end
         end

         ST_CHECK: begin
            w_state_nxt = ST_IDLE;
            if (!csum_ok(r_shift)) begin
               w_err_set      = 1'b1;
               w_err_code_nxt = ERR_CSUM;
               w_ok_clr       = 1'b1;
            end else if (!r_frame_vld || w_xfer) begin
               // a transfer this cycle frees the output register for the new frame
               w_load   = 1'b1;
               w_ok_set = 1'b1;
            end else begin
               w_err_set      = 1'b1;
               w_err_code_nxt = ERR_OVRN;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (w_shift_en) begin
         r_shift   <= {bit1_I, r_shift[31:1]};
         r_bit_cnt <= r_bit_cnt + 6'd1;
      end else if (w_cnt_clr) begin
         r_bit_cnt <= '0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_last_ok    <= 1'b0;
         r_frame_data <= '0;
         r_frame_vld  <= 1'b0;
         r_repeat     <= 1'b0;
         r_err        <= 1'b0;
         r_err_code   <= ERR_NONE;
      end else begin
         r_repeat <= w_rep_set;
         r_err    <= w_err_set;
         if (w_err_set) begin
            r_err_code <= w_err_code_nxt;
         end
         if (w_ok_set) begin
            r_last_ok <= 1'b1;
         end else if (w_ok_clr) begin
            r_last_ok <= 1'b0;
         end
         if (w_load) begin
            r_frame_data <= r_shift;
            r_frame_vld  <= 1'b1;
         end else if (w_xfer) begin
            r_frame_vld  <= 1'b0;
         end
      end
   end

   assign frame_data_O = r_frame_data;
   assign frame_vld_O  = r_frame_vld;
   assign repeat_O     = r_repeat;
   assign err_O        = r_err;
   assign err_code_O   = r_err_code;
   assign state_O      = r_state;

endmodule

// File: doc/ir_frame_ctrl.md
IR_FRAME_CTRL -- requirements
Module: ir_frame_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: CLOCK_50 and rst_n.
REQ-002 Ports (name  direction  width  meaning):
- CLOCK_50  in  1  50 MHz clock.
- rst_n  in  1  async active-low reset.
- ir_neg_I  in  1  1-cycle pulse on IRDA_RXD falling edge (burst start).
- ir_pos_I  in  1  1-cycle pulse on IRDA_RXD rising edge.
- bit0_I  in  1  1-cycle pulse: logical-0 bit classified.
- bit1_I  in  1  1-cycle pulse: logical-1 bit classified.
- frame_rdy_I  in  1  consumer ready.
- frame_data_O  out  32  decoded frame {cmd_n, cmd, addr_n, addr}; byte 0 = first received.
- frame_vld_O  out  1  frame available.
- repeat_O  out  1  1-cycle NEC repeat-code pulse.
- err_O  out  1  1-cycle error pulse.
- err_code_O  out  2  01 protocol/timeout, 10 checksum, 11 overrun; held until next error.
- state_O  out  3  current FSM state, for debug.

Function
REQ-003 Tick: 12-bit prescaler counts 0..2499, wrapping; wrap emits a 50 us tick.
REQ-004 Duration counter: 8 bits; increments per tick, saturates at 255, and is cleared (prescaler too) on any ir_neg_I or ir_pos_I.
REQ-005 States: IDLE=0, LEAD_LOW=1, LEAD_HIGH=2, DATA=3, CHECK=4.
REQ-006 IDLE: ir_neg_I -> LEAD_LOW.
REQ-007 LEAD_LOW: ir_pos_I with duration 160..200 ticks -> LEAD_HIGH; otherwise -> IDLE with no error.
REQ-008 LEAD_HIGH: on ir_neg_I, duration 80..100 -> DATA with bit count cleared.
REQ-009 LEAD_HIGH: on ir_neg_I, duration 36..54 -> IDLE; repeat_O pulses only if last_ok=1.
REQ-010 LEAD_HIGH: on ir_neg_I, any other duration -> IDLE with no error.
REQ-011 DATA: each bit0_I/bit1_I shifts the bit into bit 31 of a 32-bit shift register (right shift, LSB-first); 6-bit bit count increments.
REQ-012 DATA: after the 32nd bit -> CHECK next cycle.
REQ-013 DATA: bit0_I and bit1_I in the same cycle -> err code 01, IDLE.
REQ-014 DATA: duration counter reaching 240 (12 ms with no edge) -> err code 01, IDLE.
REQ-015 CHECK (1 cycle): cmd != ~cmd_n -> err code 10, last_ok cleared, IDLE.
REQ-016 CHECK: on pass with frame_vld_O=0 -> load frame_data_O, set frame_vld_O and last_ok, IDLE.
REQ-017 CHECK: on pass with frame_vld_O=1 and no transfer that cycle -> frame dropped, err code 11, existing data kept.
REQ-018 Address bytes SHALL NOT be checked (extended NEC allowed).
REQ-019 Handshake: transfer when frame_vld_O & frame_rdy_I are both high; frame_vld_O clears next cycle; frame_data_O stays stable while frame_vld_O=1.
REQ-020 Transfer and CHECK pass in the same cycle -> new frame loaded and frame_vld_O stays 1.
REQ-021 Bit pulses outside DATA SHALL be ignored; edges in CHECK SHALL be ignored.
REQ-022 Latency: frame_vld_O rises 2 cycles after the 32nd bit pulse; err_O/repeat_O rise 1 cycle after the causing event.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE and clear all counters, the shift register, last_ok, frame_data_O, frame_vld_O, repeat_O, err_O and err_code_O.
REQ-024 Reset mid-frame SHALL discard the partial frame; decoding resumes on the next leader after release.

Structure
REQ-025 Package ir_pkg SHALL hold the FSM state encoding, err codes, TICK_DIV=2500, and all tick windows (160/200, 80/100, 36/54, 240).
REQ-026 Sub-module ir_tick_timer SHALL implement the prescaler and saturating duration counter (REQ-003/004).
REQ-027 The FSM, shifter and handshake SHALL reside in ir_frame_ctrl.

Verification
REQ-028 Leader 9 ms low/4.5 ms high, then 32 bits of 0xE51A00FF, frame_rdy_I=1 -> frame_data_O=0xE51A00FF, one frame_vld_O cycle, err_O=0.
REQ-029 Same frame with cmd_n=0x1B -> err_O pulse, err_code_O=10, frame_vld_O stays 0.
REQ-030 Valid frame, then 9 ms/2.25 ms repeat leader -> one repeat_O pulse; after reset, the same repeat leader -> no pulse.
REQ-031 Leader, 10 bits, then idle 15 ms -> err_code_O=01 at 12 ms silence, state_O=0.
REQ-032 Two valid frames with frame_rdy_I=0 -> first frame held, err_code_O=11; raising frame_rdy_I -> first frame transferred once.
REQ-033 rst_n pulsed low after bit 16 -> all outputs 0 immediately; next full frame decodes correctly.
